// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Optional feature macro: WB_RR_EN (round-robin arbitration; fixed priority when undefined).
package regfile_wb_arbiter_pkg;

  // Register file geometry.
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Writeback requester indices.
  localparam int WB_ALU  = 0;
  localparam int WB_LOAD = 1;
  localparam int WB_MDU  = 2;

endpackage

// File: rtl/regfile_wb_arbiter_pick.sv
// One-hot grant picker for the writeback arbiter.
// WB_RR_EN defined: round-robin, the search starts one past ptr.
// WB_RR_EN undefined: fixed priority, lowest index wins, ptr is ignored.
module wb_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

`ifdef WB_RR_EN
  logic found;
  int   idx;

  // Walk the requesters starting after the last winner; first holder wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == idx) && req[j]) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`else
  logic found;
  logic ptr_unused;

  // The pointer has no meaning for a fixed-priority pick.
  assign ptr_unused = ^ptr;

  // Lowest-index holder wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file. Each writeback source owns a
// one-entry holding register; one held write per cycle drives rf_we/rf_waddr/rf_wdata.
// Writes to register 0 are accepted and discarded.
// Optional feature macro: WB_RR_EN (round-robin instead of fixed priority).
import regfile_wb_arbiter_pkg::*;

module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  // Handshake: requester i transfers at a rising edge where req_valid[i] && req_ready[i].
  // req_ready[i] depends only on held state (empty, or being drained this cycle), never
  // on req_valid, and addr/data are sampled only at the accepting edge.
  logic [NUM_REQ-1:0] hold_valid;
  logic [ADDR_W-1:0]  hold_addr [NUM_REQ];
  logic [DATA_W-1:0]  hold_data [NUM_REQ];
  logic [NUM_REQ-1:0] accept;
  logic [PTR_W-1:0]   pick_ptr;

  assign req_ready = ~hold_valid | grant;
  assign accept    = req_valid & req_ready;
  assign busy      = |hold_valid;
  assign rf_we     = |grant;

  wb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req   (hold_valid),
    .ptr   (pick_ptr),
    .grant (grant)
  );

  // Holding registers: load on accept (unless $0), release when granted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hold_addr[i] <= '0;
        hold_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          hold_valid[i] <= (req_addr[i*ADDR_W +: ADDR_W] != ZERO_ADDR);
          if (req_addr[i*ADDR_W +: ADDR_W] != ZERO_ADDR) begin
            hold_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
            hold_data[i] <= req_data[i*DATA_W +: DATA_W];
          end
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Output mux: OR of grant-masked entries, so idle cycles drive zeros.
  always_comb begin
    rf_waddr = '0;
    rf_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        rf_waddr = rf_waddr | hold_addr[i];
        rf_wdata = rf_wdata | hold_data[i];
      end
    end
  end

`ifdef WB_RR_EN
  logic [PTR_W-1:0] last_grant;
  logic [PTR_W-1:0] grant_idx;

  // Encode the one-hot grant into an index for the round-robin pointer.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = PTR_W'(i);
    end
  end

  // Remember the last winner; reset value makes requester 0 first in line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant <= PTR_W'(NUM_REQ - 1);
    end else if (rf_we) begin
      last_grant <= grant_idx;
    end
  end

  assign pick_ptr = last_grant;
`else
  assign pick_ptr = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued as stimulus is
// driven and popped when the DUT asserts rf_we.
module tb_regfile_wb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int W       = NUM_REQ + ADDR_W + DATA_W;

  logic                      clock;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_waddr;
  logic [DATA_W-1:0]         rf_wdata;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;

  logic [W-1:0] exp_q[$];
  int           n_cmp;
  int           n_fail;
  logic         mon_en;

  regfile_wb_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .grant     (grant),
    .busy      (busy)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ew(input int i, input logic [ADDR_W-1:0] a,
                                      input logic [DATA_W-1:0] d);
    logic [NUM_REQ-1:0] g;
    g = NUM_REQ'(1) << i;
    return {g, a, d};
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req_valid[i]                = v;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    step();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    step();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: every write the DUT issues must match the head of the expected queue.
  always @(negedge clock) begin
    if (mon_en && rf_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", {63'd0, rf_we}, 64'd0);
      end else begin
        check("wb_write", 64'({grant, rf_waddr, rf_wdata}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic acc;
    logic [ADDR_W-1:0] a;
    n_cmp  = 0;
    n_fail = 0;
    mon_en = 1'b0;
    reset  = 1'b0;
    clear_reqs();

    // Reset with random inputs: everything quiet, all requesters ready.
    for (int k = 0; k < 3; k++) begin
      req_valid = NUM_REQ'($urandom_range(0, 7));
      req_addr  = {5'($urandom), 5'($urandom), 5'($urandom)};
      req_data  = {$urandom(), $urandom(), $urandom()};
      #7;
      check("rst_we",    {63'd0, rf_we}, 64'd0);
      check("rst_waddr", 64'(rf_waddr), 64'd0);
      check("rst_wdata", 64'(rf_wdata), 64'd0);
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_busy",  {63'd0, busy}, 64'd0);
      check("rst_ready", 64'(req_ready), 64'd7);
    end
    clear_reqs();
    step();
    reset  = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("idle_we", {63'd0, rf_we}, 64'd0);
    end

    // Single requester back-to-back: ready never drops, one write per cycle.
    for (int k = 0; k < 3; k++) begin
      a = ADDR_W'(5 + k);
      set_req(1, 1'b1, a, 32'h11 * (k + 1));
      exp_q.push_back(ew(1, a, 32'h11 * (k + 1)));
      check("b2b_ready", {63'd0, req_ready[1]}, 64'd1);
      step();
    end
    set_req(1, 1'b0, '0, '0);
    check("b2b_last_write", {63'd0, rf_we}, 64'd1);
    drain("b2b_drain");

    // Three-way contention from reset: grant order 001, 010, 100.
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'hA1);
    set_req(1, 1'b1, 5'd2, 32'hA2);
    set_req(2, 1'b1, 5'd3, 32'hA3);
    exp_q.push_back(ew(0, 5'd1, 32'hA1));
    exp_q.push_back(ew(1, 5'd2, 32'hA2));
    exp_q.push_back(ew(2, 5'd3, 32'hA3));
    step();
    clear_reqs();
    check("cont_busy", {63'd0, busy}, 64'd1);
    check("cont_first_grant", 64'(grant), 64'd1);
    drain("cont_drain");

    // Fairness: requester 0 streams addrs 8..11, requester 2 requests once.
    do_reset();
`ifdef WB_RR_EN
    exp_q.push_back(ew(0, 5'd8,  32'h80));
    exp_q.push_back(ew(2, 5'd20, 32'h200));
    exp_q.push_back(ew(0, 5'd9,  32'h90));
    exp_q.push_back(ew(0, 5'd10, 32'hA0));
    exp_q.push_back(ew(0, 5'd11, 32'hB0));
`else
    exp_q.push_back(ew(0, 5'd8,  32'h80));
    exp_q.push_back(ew(0, 5'd9,  32'h90));
    exp_q.push_back(ew(0, 5'd10, 32'hA0));
    exp_q.push_back(ew(0, 5'd11, 32'hB0));
    exp_q.push_back(ew(2, 5'd20, 32'h200));
`endif
    set_req(0, 1'b1, 5'd8,  32'h80);
    set_req(2, 1'b1, 5'd20, 32'h200);
    check("fair_ready", 64'(req_ready), 64'd7);
    step();
    set_req(2, 1'b0, '0, '0);
    for (int k = 1; k < 4; k++) begin
      a = ADDR_W'(8 + k);
      set_req(0, 1'b1, a, 32'h80 + 32'h10 * k);
      acc = 1'b0;
      for (int t = 0; t < 10 && !acc; t++) begin
        acc = req_ready[0];
        step();
      end
      check("fair_stream_accept", {63'd0, acc}, 64'd1);
    end
    set_req(0, 1'b0, '0, '0);
    drain("fair_drain");

    // $0 write: accepted, never issued, never held.
    set_req(0, 1'b1, 5'd0, 32'hDEAD);
    check("zero_ready", {63'd0, req_ready[0]}, 64'd1);
    step();
    set_req(0, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      check("zero_busy", {63'd0, busy}, 64'd0);
      check("zero_we", {63'd0, rf_we}, 64'd0);
      step();
    end

    // Reset mid-operation: held writes vanish and rf_we drops at once.
    set_req(0, 1'b1, 5'd4, 32'h44);
    set_req(1, 1'b1, 5'd5, 32'h55);
    set_req(2, 1'b1, 5'd6, 32'h66);
    step();
    clear_reqs();
    check("mid_busy_before", {63'd0, busy}, 64'd1);
    check("mid_we_before", {63'd0, rf_we}, 64'd1);
    reset = 1'b0;
    #1;
    check("mid_we_reset", {63'd0, rf_we}, 64'd0);
    check("mid_busy_reset", {63'd0, busy}, 64'd0);
    check("mid_grant_reset", 64'(grant), 64'd0);
    #2;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("mid_no_stale", {63'd0, rf_we}, 64'd0);
    end

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the 32×32 register file. Multiple writeback sources (ALU writeback, load writeback, multiply/divide unit) share the register file's single write port. Each source has a one-entry holding register. Each cycle, one held write is granted and driven onto the register file's RegWrite/WriteReg/WriteData inputs. Writes to $0 are accepted and discarded.

## Interface
Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester accept
- req_addr  in  NUM_REQ*ADDR_W  flattened destination registers; requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  flattened write data; requester i occupies bits [i*DATA_W +: DATA_W]
- rf_we  out  1  to the register file's RegWrite
- rf_waddr  out  ADDR_W  to the register file's WriteReg
- rf_wdata  out  DATA_W  to the register file's WriteData
- grant  out  NUM_REQ  one-hot; marks the holding entry driving rf_* this cycle
- busy  out  1  OR of all hold_valid bits

## Operation
- Per requester i: hold_valid[i], hold_addr[i], hold_data[i].
- Acceptance rule: req_ready[i] = !hold_valid[i] || grant[i]. A request is accepted at a rising edge where req_valid[i] && req_ready[i].
- On accept with req_addr != 0: load the hold entry and set hold_valid[i].
- On accept with req_addr == 0: the write is dropped and hold_valid[i] stays/becomes 0.
- If granted and no new accept occurs: hold_valid[i] clears at that edge.
- If granted and a new accept occurs at the same edge: the entry reloads, and hold_valid stays 1.
- Arbitration is combinational over hold_valid. At most one grant bit is set per cycle.
- rf_we = |grant. rf_waddr and rf_wdata are muxed from the granted entry. Both are 0 when no grant is asserted.
- With WB_RR_EN, a round-robin pointer last_grant (index width clog2(NUM_REQ)) updates to the granted index at every edge with rf_we=1.
- There is no ordering guarantee between requesters. If two entries target the same register, the later-granted write wins. Requesters (the hazard unit) must avoid this case when ordering matters.
- req_addr and req_data are not required to be stable while req_valid is high and req_ready is low. Only the value at the accepting edge is captured.

## Timing
- Reset (asynchronous assert, synchronous release into clock domain by the top level):
  - hold_valid = 0, hold_addr = 0, hold_data = 0.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
  - Outputs: rf_we=0, rf_waddr=0, rf_wdata=0, grant=0, busy=0, req_ready = all 1.
- Latency:
  - Accept at edge N, then earliest rf_we=1 during cycle N→N+1, then the register file writes at edge N+1.
- Throughput:
  - The port sustains 1 write/cycle in aggregate.
  - A single uncontended requester also sustains 1/cycle, because ready holds while its entry is granted.
- Worst-case wait with round-robin: NUM_REQ-1 cycles behind other holders.
- Reset mid-operation: all held writes are lost and no partial write is issued. rf_we drops asynchronously.
- Combinational paths: hold regs → grant → req_ready/rf_*. There is no combinational path from req_valid to any output.

## Configuration
- WB_RR_EN defined: round-robin arbitration. The search starts at last_grant+1 (mod NUM_REQ).
- WB_RR_EN undefined: fixed priority with lowest index highest. The last_grant register is not instantiated. A requester with a persistent stream can starve higher indices.

## Structure
- Shared package/include:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0.
  - Requester index constants: WB_ALU=0, WB_LOAD=1, WB_MDU=2.
- One sub-module: wb_rr_pick (inputs: request vector, pointer; output: one-hot grant). Under WB_RR_EN it is round-robin. Otherwise it is a priority encoder with the pointer ignored.
- Holding registers and the output mux live in regfile_wb_arbiter.

## Test plan
- Reset check: assert reset with random inputs → all outputs 0, req_ready=3'b111. Release, then hold req_valid=0 for 10 cycles → rf_we stays 0.
- Single requester, back-to-back: requester 1 sends (addr 5, 0x11), (6, 0x22), (7, 0x33) on consecutive edges → rf_we=1 for 3 consecutive cycles with those addr/data. req_ready[1] is never low.
- Three-way contention, WB_RR_EN: all three requesters present addr 1/2/3 at the same edge and hold valid → grant order 001, 010, 100. Register file ends with R1, R2, R3 written.
- Fairness: requester 0 streams continuously and requester 2 requests once → under WB_RR_EN, requester 2 is granted within 2 cycles. Without WB_RR_EN, requester 2 waits until requester 0 stops.
- $0 drop: requester 0 sends (addr 0, 0xDEAD) → accepted, rf_we never asserted for it, busy stays 0.
- Reset mid-operation: fill all three entries, assert reset → rf_we=0 immediately. After release, no stale write is issued.
